ripple_tick_ctrl: RTL and testbench

Wishbone-controlled tick generator sitting directly upstream of the user-area ripple counter. Software programs an enable and a prescale divisor. The block emits a one-cycle count-enable pulse every PRESCALE+1 clocks, plus a one-cycle clear pulse. It also mirrors the expected counter value (ticks modulo 2^CNT_W) for readback and raises an interrupt on each counter wrap.

---
 rtl/ripple_tick_pkg.sv | 17 +
 rtl/ripple_prescaler.sv | 37 +++
 rtl/ripple_tick_ctrl.sv | 160 ++++++++++++++++
 tb/tb_ripple_tick_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_tick_pkg.sv
// ripple_tick_ctrl shared definitions
// register offsets and bit positions
package ripple_tick_pkg;

  localparam logic [1:0] REG_CTRL     = 2'd0;
  localparam logic [1:0] REG_PRESCALE = 2'd1;
  localparam logic [1:0] REG_TICKS    = 2'd2;
  localparam logic [1:0] REG_STATUS   = 2'd3;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_CLR   = 1;
  localparam int CTRL_IRQEN = 2;

  localparam int STAT_WRAP = 0;
  localparam int STAT_EN   = 1;

endpackage

// File: rtl/ripple_prescaler.sv
// ripple_prescaler: divides the clock down to
// a one-cycle tick every prescale+1 cycles
module ripple_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] prescale,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             due;

  // >= so a lowered divisor fires at once
  always_comb begin
    due       = div_cnt_q >= prescale;
    tick      = en & ~clr & due;
    div_cnt_d = div_cnt_q + DIV_W'(1);
    if (!en || clr || due) begin
      div_cnt_d = '0;
    end
  end

  // divider state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/ripple_tick_ctrl.sv
// ripple_tick_ctrl: wishbone regs, tick mirror
// and wrap interrupt for the ripple counter
module ripple_tick_ctrl
  import ripple_tick_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          DIV_W       = 16,
  parameter int          DEFAULT_DIV = 3,
  parameter int          CNT_W       = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cnt_tick_o,
  output logic        cnt_clr_o,
  output logic        irq_o
);

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic             en_q, en_d;
  logic             irq_en_q, irq_en_d;
  logic             clr_q, clr_d;
  logic [DIV_W-1:0] prescale_q, prescale_d;
  logic [CNT_W-1:0] ticks_q, ticks_d;
  logic             wrap_q, wrap_d;

  logic             sel;
  logic             acc;
  logic             wr;
  logic [1:0]       idx;
  logic [31:0]      rdata;
  logic             w1c;
  logic             wrap_set;
  logic             tick;
  logic             unused_bits;

  assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

  ripple_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .en       (en_q),
    .clr      (clr_q),
    .prescale (prescale_q),
    .tick     (tick)
  );

  // address decode; one ack per access
  always_comb begin
    sel = wbs_cyc_i & wbs_stb_i
        & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    acc = sel & ~ack_q;
    wr  = acc & wbs_we_i;
    idx = wbs_adr_i[3:2];
  end

  // read mux
  always_comb begin
    rdata = '0;
    unique case (idx)
      REG_CTRL: begin
        rdata[CTRL_EN]    = en_q;
        rdata[CTRL_IRQEN] = irq_en_q;
      end
      REG_PRESCALE: rdata[DIV_W-1:0] = prescale_q;
      REG_TICKS:    rdata[CNT_W-1:0] = ticks_q;
      REG_STATUS: begin
        rdata[STAT_WRAP] = wrap_q;
        rdata[STAT_EN]   = en_q;
      end
      default: ;
    endcase
  end

  // register writes, byte-masked
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    clr_d      = 1'b0;
    prescale_d = prescale_q;
    w1c        = 1'b0;
    if (wr) begin
      unique case (idx)
        REG_CTRL: begin
          if (wbs_sel_i[0]) begin
            en_d     = wbs_dat_i[CTRL_EN];
            irq_en_d = wbs_dat_i[CTRL_IRQEN];
            clr_d    = wbs_dat_i[CTRL_CLR];
          end
        end
        REG_PRESCALE: begin
          for (int i = 0; i < DIV_W; i++) begin
            if (wbs_sel_i[i/8]) begin
              prescale_d[i] = wbs_dat_i[i];
            end
          end
        end
        REG_STATUS: begin
          w1c = wbs_sel_i[0] & wbs_dat_i[STAT_WRAP];
        end
        default: ;
      endcase
    end
  end

  // tick mirror and wrap flag; set beats clear
  always_comb begin
    ticks_d  = ticks_q;
    wrap_set = 1'b0;
    if (clr_q) begin
      ticks_d = '0;
    end else if (tick) begin
      ticks_d  = ticks_q + CNT_W'(1);
      wrap_set = &ticks_q;
    end
    wrap_d = (wrap_q & ~w1c) | wrap_set;
    ack_d  = acc;
    dat_d  = acc ? rdata : 32'h0;
  end

  // state registers
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      clr_q      <= 1'b0;
      prescale_q <= DIV_W'(DEFAULT_DIV);
      ticks_q    <= '0;
      wrap_q     <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      clr_q      <= clr_d;
      prescale_q <= prescale_d;
      ticks_q    <= ticks_d;
      wrap_q     <= wrap_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign cnt_tick_o = tick;
  assign cnt_clr_o  = clr_q;
  assign irq_o      = wrap_q & irq_en_q;

endmodule

// File: tb/tb_ripple_tick_ctrl.sv
// tb_ripple_tick_ctrl: directed vectors and
// timed sequences for ripple_tick_ctrl
module tb_ripple_tick_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_PRES = BASE + 32'h4;
  localparam logic [31:0] A_TICK = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, dat_i = 32'h0;
  logic        ack;
  logic [31:0] dat_o;
  logic        tick, clr, irq;

  int total = 0;
  int passed = 0;
  int clr_pulses = 0;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[13];

  always #5 clk = ~clk;

  always @(negedge clk) if (clr) clr_pulses++;

  ripple_tick_ctrl dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (dat_i),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (dat_o),
    .cnt_tick_o (tick),
    .cnt_clr_o  (clr),
    .irq_o      (irq)
  );

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h want %h",
                  name, got, exp);
  endtask

  task automatic wb_access(input logic w,
                           input logic [31:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s,
                           output logic [31:0] r,
                           output logic ok);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; dat_i = d; sel = s;
    ok = 1'b0; r = 32'h0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(posedge clk); #1;
      if (ack) begin ok = 1'b1; r = dat_o; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [3:0] s);
    logic [31:0] r;
    logic ok;
    wb_access(1'b1, a, d, s, r, ok);
    if (!ok) begin
      total++;
      $display("FAIL wr_ack %h: got none want ack", a);
    end
  endtask

  task automatic rd(input logic [31:0] a,
                    input string name,
                    input logic [31:0] exp);
    logic [31:0] r;
    logic ok;
    wb_access(1'b0, a, 32'h0, 4'hF, r, ok);
    check(name, ok ? r : 32'hxxxx_xxxx, exp);
  endtask

  task automatic run_vec(input int i);
    if (tbl[i].we) wr(tbl[i].adr, tbl[i].dat, tbl[i].sel);
    else rd(tbl[i].adr, tbl[i].name, tbl[i].exp);
  endtask

  // k=0 is the current cycle
  task automatic expect_ticks(input string name,
                              input int n,
                              input int period,
                              input int first);
    int bad;
    logic e;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      e = (k >= first) && ((k - first) % period == 0);
      if (tick !== e) bad++;
    end
    check(name, bad, 0);
  endtask

  task automatic no_ack(input logic [31:0] a,
                        input string name);
    int n;
    n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = a; dat_i = 32'hFFFF_FFFF; sel = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ack) n++;
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check(name, n, 0);
  endtask

  initial begin
    int q;
    int c0;
    logic [5:0] pat;

    tbl[0]  = '{1'b0, A_CTRL, 32'h0, 4'hF, 32'h0, "rst_ctrl"};
    tbl[1]  = '{1'b0, A_PRES, 32'h0, 4'hF, 32'h3, "rst_pres"};
    tbl[2]  = '{1'b0, A_TICK, 32'h0, 4'hF, 32'h0, "rst_ticks"};
    tbl[3]  = '{1'b0, A_STAT, 32'h0, 4'hF, 32'h0, "rst_stat"};
    tbl[4]  = '{1'b1, A_PRES, 32'hABCD, 4'h1, 32'h0, ""};
    tbl[5]  = '{1'b0, A_PRES, 32'h0, 4'hF, 32'hCD, "pres_b0"};
    tbl[6]  = '{1'b1, A_PRES, 32'h1234_5678, 4'hC, 32'h0, ""};
    tbl[7]  = '{1'b0, A_PRES, 32'h0, 4'hF, 32'hCD, "pres_hi"};
    tbl[8]  = '{1'b1, A_PRES, 32'hFFFF, 4'h0, 32'h0, ""};
    tbl[9]  = '{1'b0, A_PRES, 32'h0, 4'hF, 32'hCD, "pres_sel0"};
    tbl[10] = '{1'b1, A_TICK, 32'h3, 4'hF, 32'h0, ""};
    tbl[11] = '{1'b0, A_TICK, 32'h0, 4'hF, 32'h0, "ticks_ro"};
    tbl[12] = '{1'b1, A_PRES, 32'hFFFF_0003, 4'hF, 32'h0, ""};

    repeat (3) @(posedge clk);
    #1;
    check("in_reset", {28'h0, ack, tick, clr, irq}, 32'h0);
    check("in_reset_dat", dat_o, 32'h0);
    rst_n = 1'b1;

    q = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (tick | clr | irq | ack) q++;
    end
    check("quiet", q, 0);

    for (int i = 0; i < 13; i++) run_vec(i);
    rd(A_PRES, "pres_restore", 32'h3);

    // period 4, wrap after 4 ticks
    wr(A_CTRL, 32'h1, 4'hF);
    expect_ticks("period4", 16, 4, 3);
    @(posedge clk); #1;
    rd(A_TICK, "ticks_wrap", 32'h0);
    rd(A_STAT, "stat_wrap", 32'h3);
    check("irq_masked", irq, 1'b0);
    wr(A_CTRL, 32'h5, 4'hF);
    check("irq_on", irq, 1'b1);
    wr(A_CTRL, 32'h4, 4'hF);
    check("irq_hold", irq, 1'b1);
    wr(A_STAT, 32'h1, 4'hF);
    check("irq_w1c", irq, 1'b0);
    rd(A_STAT, "stat_w1c", 32'h0);

    // divisor changes
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_PRES, 32'h0, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    expect_ticks("period1", 8, 1, 0);
    wr(A_PRES, 32'h9, 4'hF);
    expect_ticks("period10", 20, 10, 9);
    repeat (7) begin @(posedge clk); #1; end
    wr(A_PRES, 32'h2, 4'hF);
    expect_ticks("pres_lower", 10, 3, 0);

    // clear while running
    wr(A_CTRL, 32'h0, 4'hF);
    wr(A_PRES, 32'h3, 4'hF);
    wr(A_CTRL, 32'h2, 4'hF);
    wr(A_CTRL, 32'h1, 4'hF);
    expect_ticks("pre_clr", 8, 4, 3);
    @(posedge clk); #1;
    rd(A_TICK, "ticks_2", 32'h2);
    c0 = clr_pulses;
    wr(A_CTRL, 32'h3, 4'hF);
    check("clr_high", clr, 1'b1);
    expect_ticks("post_clr", 5, 4, 4);
    rd(A_TICK, "ticks_clr", 32'h0);
    check("clr_once", clr_pulses - c0, 1);
    rd(A_CTRL, "ctrl_clr_rd", 32'h1);

    // decode and handshake
    wr(A_CTRL, 32'h0, 4'hF);
    no_ack(BASE + 32'h10, "noack_0x10");
    no_ack(32'h2000_0004, "noack_base");
    rd(A_PRES, "pres_kept", 32'h3);
    rd(A_CTRL, "ctrl_kept", 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = A_PRES; sel = 4'hF;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pat[k] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    check("b2b_acks", pat, 6'b010101);

    // async reset mid-run
    wr(A_PRES, 32'h0, 4'hF);
    wr(A_CTRL, 32'h5, 4'hF);
    repeat (8) begin @(posedge clk); #1; end
    check("pre_rst_tick", tick, 1'b1);
    check("pre_rst_irq", irq, 1'b1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {28'h0, ack, tick, clr, irq}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) run_vec(i);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
